if_fetch_unit: RTL

Instruction-fetch stage front end for the MIPS pipeline. Owns the PC, issues word requests to the instruction memory over a ready/valid handshake, absorbs one response through a one-entry buffer when the pipeline stalls, and produces the write-enable, flush, PC+4 and instruction that load the IF/ID pipeline register. Sits between instruction memory and IF/ID. Receives stall from the hazard unit and redirect from the branch/jump resolution logic.

---
 rtl/mips_pipeline_pkg.sv | 13 +
 rtl/if_fetch_buffer.sv | 58 +++++
 rtl/if_fetch_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/mips_pipeline_pkg.sv
// Shared constants for the MIPS pipeline front end.
// Fetch FSM encodings, PC increment and reset defaults.
package mips_pipeline_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam int unsigned PC_INCR = 4;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_buffer.sv
// One-entry holding register for a fetched pc/instr pair.
// Absorbs a response that arrives while IF/ID is stalled.
module if_fetch_buffer
    import mips_pipeline_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic                   consume_i,
    input  logic [ADDR_WIDTH-1:0]  pc_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    output logic                   valid_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic [INSTR_WIDTH-1:0] instr_o
);

    logic                   valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;

    // Clear beats load, load beats consume.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage front end: owns the PC, talks to instruction memory,
// and produces the IF/ID load/flush controls and payload.
module if_fetch_unit
    import mips_pipeline_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    =
        RESET_PC_DEFAULT[ADDR_WIDTH-1:0]
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   if_id_write,
    output logic                   flush,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic [INSTR_WIDTH-1:0] instr_out
);

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;

    logic                   buf_vld;
    logic [ADDR_WIDTH-1:0]  buf_pc;
    logic [INSTR_WIDTH-1:0] buf_instr;

    logic live_vld;
    logic buf_load;
    logic buf_cons;
    logic buf_vld_nxt;
    logic fetch_vld;
    logic req;
    logic accept;

    // pc_q already points past the outstanding word, so it is that
    // word's pc+4 whenever a wanted response is live.
    assign live_vld    = (state_q == ST_WAIT) & imem_rvalid;
    assign buf_load    = live_vld & stall & ~redirect & ~buf_vld;
    assign buf_cons    = buf_vld & ~stall & ~redirect;
    assign buf_vld_nxt = (buf_vld & ~buf_cons) | buf_load;
    assign fetch_vld   = (buf_vld | live_vld) & ~redirect;

    assign req = ~redirect & ~buf_vld_nxt &
                 ((state_q == ST_IDLE) | live_vld);
    assign accept = reset_n & req & imem_ready;

    if_fetch_buffer #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (redirect),
        .load_i    (buf_load),
        .consume_i (buf_cons),
        .pc_i      (pc_q),
        .instr_i   (imem_rdata),
        .valid_o   (buf_vld),
        .pc_o      (buf_pc),
        .instr_o   (buf_instr)
    );

    // Next PC and request state; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
            if ((state_q != ST_IDLE) && !imem_rvalid) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (accept) begin
            pc_d    = pc_q + ADDR_WIDTH'(PC_INCR);
            state_d = ST_WAIT;
        end else if ((state_q != ST_IDLE) && imem_rvalid) begin
            state_d = ST_IDLE;
        end
    end

    // PC and FSM registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            state_q <= ST_IDLE;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign imem_req    = reset_n & req;
    assign imem_addr   = pc_q;
    assign if_id_write = reset_n & fetch_vld & ~stall;
    assign flush       = reset_n & (redirect | (~fetch_vld & ~stall));
    assign pc_out      = !reset_n ? '0 : (buf_vld ? buf_pc : pc_q);
    assign instr_out   = !reset_n ? '0 : (buf_vld ? buf_instr : imem_rdata);

endmodule
